lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store controller sitting directly upstream of the data memory, between the CPU execute/memory stage and the Mem block.
- Accepts one load or store request at a time.
- Generates the memory-side CS/RW/BE/word address.
- Lane-aligns store data; extracts and sign/zero-extends load data.
- Waits on DataReady with a timeout, then returns a single-cycle Done.

Parameters:
TIMEOUT_CYCLES, 15, max WAIT cycles without MemReady before a bus error (1..255)
CNT_W, 8, width of the wait counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous active-low reset (0 = reset, sampled on Clk rising edge)
Req  in  1  request strobe; accepted only when Busy=0
Wr  in  1  1=store, 0=load
Size  in  2  0=byte, 1=half, 2=word, 3=treated as word
Signed  in  1  loads: 1=sign-extend, 0=zero-extend
Addr  in  32  byte address
WData  in  32  store data, right-justified
Busy  out  1  request in progress
Done  out  1  one-cycle completion pulse
RData  out  32  extended load data; valid with Done, held until next Done
BusErr  out  1  timeout flag, valid with Done
AddrErr  out  1  misalignment flag, valid with Done (see Optional Feature)
MemCS  out  1  memory chip select
MemRW  out  1  1=write, 0=read
MemBE  out  4  byte enables; bit k = byte lane k (little-endian)
MemAddr  out  30  word address, equals Addr[31:2]
MemDataOut  out  32  aligned store data to memory DataIn
MemDataIn  in  32  memory DataOut (registered in memory)
MemReady  in  1  memory DataReady

Behaviour:
- Reset=0 at an edge: state IDLE; Busy, Done, BusErr, AddrErr, MemCS, MemRW = 0; MemBE, MemAddr, MemDataOut, RData, counter = 0. Applies mid-transaction: no Done is produced and the access is abandoned.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on Req=1, capture Wr/Size/Signed/Addr/WData, set Busy=1, go to ISSUE.
- Req while Busy=1 is ignored; requests are not queued.
- ISSUE (1 cycle): MemCS=1, MemRW=Wr, MemAddr=Addr[31:2], MemBE and MemDataOut from the lane rules. Go to WAIT.
- WAIT:
  - All memory outputs are held stable; counter increments each cycle.
  - MemReady=1: latch extended MemDataIn into RData (loads only; stores leave RData unchanged), go to RESP.
  - Counter reaches TIMEOUT_CYCLES with MemReady still 0: BusErr=1, RData=0, go to RESP.
- RESP: MemCS=0, Done=1 for one cycle, Busy=0 at the next edge, return to IDLE.
- A new Req is accepted in the cycle after RESP at the earliest.
- Nominal latency: accept at edge T, ISSUE T+1, WAIT T+2, Done high in cycle T+3.
- MemBE rules:
  - byte: 1 << Addr[1:0]
  - half: Addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word passed through.
- Load extraction: byte = lane Addr[1:0]; half = Addr[1] ? [31:16] : [15:0]; extended to 32 bits per Signed.
- BusErr and AddrErr are cleared when the next request is accepted.

Optional Feature:
LSU_ALIGN_CHK_EN
- Defined:
  - Misaligned requests are detected: half with Addr[0]=1, or word with Addr[1:0]≠0.
  - Such a request skips ISSUE/WAIT and goes straight to RESP with AddrErr=1.
  - MemCS is never asserted for it; Done is high in cycle T+1.
- Undefined:
  - No misalignment check; AddrErr is tied 0.
  - Half uses only Addr[1]; word ignores Addr[1:0].

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - BE constants
- Sub-module lsu_lane_align (combinational):
  - Inputs: Size, Addr[1:0], Signed, WData, MemDataIn.
  - Outputs: MemBE, aligned store data, extended load data.
- FSM and timeout counter stay in lsu_ctrl.

Test Plan:
- Store word, Addr=0x40, WData=0xDEADBEEF -> MemAddr=0x10, MemBE=1111, MemDataOut=0xDEADBEEF, MemRW=1 in ISSUE; Done in cycle T+3.
- Store byte, Addr=0x43, WData=0x000000A5 -> MemBE=1000, MemDataOut=0xA5A5A5A5.
- Memory word 0x12F03456, load byte at Addr=0x42 -> Signed=1: RData=0xFFFFFFF0; Signed=0: RData=0x000000F0. Load half at Addr=0x42, Signed=1 -> RData=0x000012F0.
- MemReady held 0, TIMEOUT_CYCLES=15 -> Done after 15 WAIT cycles with BusErr=1 and RData=0; the next request clears BusErr.
- Reset driven 0 during WAIT -> next edge MemCS=0, Busy=0; Done never asserted; a fresh Req afterwards completes normally.
- With LSU_ALIGN_CHK_EN: word load at Addr=0x42 -> AddrErr=1, Done in cycle T+1, MemCS stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller and its lane-steering helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Size code 3 is not a distinct width; it behaves exactly like a word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between right-justified CPU data and the 32-bit memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] store_data_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Without the alignment check a half access only looks at Addr[1].
    assign byte_lane = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        be_o         = BE_WORD;
        store_data_o = wdata_i;
        load_data_o  = mem_rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o         = BE_BYTE0 << addr_lo_i;
                store_data_o = {4{wdata_i[7:0]}};
                load_data_o  = {{24{signed_i & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                be_o         = addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
                store_data_o = {2{wdata_i[15:0]}};
                load_data_o  = {{16{signed_i & half_lane[15]}}, half_lane};
            end
            default: begin
                be_o         = BE_WORD;
                store_data_o = wdata_i;
                load_data_o  = mem_rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access at a time into the data memory, bounded by a wait timeout.
// Build option: define LSU_ALIGN_CHK_EN to reject misaligned half/word requests without a memory access.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RData,
    output logic        BusErr,
    output logic        AddrErr,
    output logic        MemCS,
    output logic        MemRW,
    output logic [3:0]  MemBE,
    output logic [29:0] MemAddr,
    output logic [31:0] MemDataOut,
    input  logic [31:0] MemDataIn,
    input  logic        MemReady
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e       state_q, state_d;
    logic             wr_q, wr_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             addr_err_q, addr_err_d;

    logic [3:0]       lane_be;
    logic [31:0]      lane_store;
    logic [31:0]      lane_load;
    logic             mem_active;

    lsu_lane_align u_lane_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .signed_i     (signed_q),
        .wdata_i      (wdata_q),
        .mem_rdata_i  (MemDataIn),
        .be_o         (lane_be),
        .store_data_o (lane_store),
        .load_data_o  (lane_load)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        bus_err_d  = bus_err_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    wr_d       = Wr;
                    size_d     = Size;
                    signed_d   = Signed;
                    addr_d     = Addr;
                    wdata_d    = WData;
                    cnt_d      = '0;
                    bus_err_d  = 1'b0;
                    addr_err_d = 1'b0;
                    state_d    = ST_ISSUE;
`ifdef LSU_ALIGN_CHK_EN
                    if (is_misaligned(Size, Addr[1:0])) begin
                        addr_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (MemReady) begin
                    if (!wr_q) begin
                        rdata_d = lane_load;
                    end
                    state_d = ST_RESP;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs are only driven while an access is on the bus and read as zero otherwise.
    always_comb begin
        mem_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        Busy       = (state_q != ST_IDLE);
        Done       = (state_q == ST_RESP);
        RData      = rdata_q;
        BusErr     = bus_err_q;
        AddrErr    = addr_err_q;
        MemCS      = mem_active;
        MemRW      = mem_active & wr_q;
        MemBE      = mem_active ? lane_be : BE_NONE;
        MemAddr    = mem_active ? addr_q[31:2] : '0;
        MemDataOut = mem_active ? lane_store : '0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl against a byte-level memory reference model.
module tb_lsu_ctrl;

    localparam int TO         = 15;
    localparam int NUM_RANDOM = 150;

    logic        Clk        = 1'b0;
    logic        Reset      = 1'b0;
    logic        Req        = 1'b0;
    logic        Wr         = 1'b0;
    logic [1:0]  Size       = 2'd0;
    logic        Signed     = 1'b0;
    logic [31:0] Addr       = 32'h0;
    logic [31:0] WData      = 32'h0;
    logic        Busy;
    logic        Done;
    logic [31:0] RData;
    logic        BusErr;
    logic        AddrErr;
    logic        MemCS;
    logic        MemRW;
    logic [3:0]  MemBE;
    logic [29:0] MemAddr;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn  = 32'h0;
    logic        MemReady   = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        busErr;
        logic        addrErr;
        int          doneCycle;
    } expResp_t;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          checkData;
    } busExp_t;

    expResp_t    respQ[$];
    busExp_t     busQ[$];
    busExp_t     curBus;
    logic [7:0]  refMem [0:127];
    logic [31:0] tbMem  [0:31];
    logic [31:0] lastRData = 32'h0;
    int          cycle       = 0;
    int          checks      = 0;
    int          failures    = 0;
    int          respLatency = -1;
    int          csCount     = 0;
    bit          csPrev      = 1'b0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Wr         (Wr),
        .Size       (Size),
        .Signed     (Signed),
        .Addr       (Addr),
        .WData      (WData),
        .Busy       (Busy),
        .Done       (Done),
        .RData      (RData),
        .BusErr     (BusErr),
        .AddrErr    (AddrErr),
        .MemCS      (MemCS),
        .MemRW      (MemRW),
        .MemBE      (MemBE),
        .MemAddr    (MemAddr),
        .MemDataOut (MemDataOut),
        .MemDataIn  (MemDataIn),
        .MemReady   (MemReady)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Memory stand-in: answers after respLatency WAIT cycles (never when negative), writes on its answer.
    always @(negedge Clk) begin
        if (MemCS) begin
            csCount++;
            if (respLatency >= 0 && csCount == respLatency + 2) begin
                MemReady  = 1'b1;
                MemDataIn = tbMem[MemAddr[4:0]];
                if (MemRW) begin
                    for (int k = 0; k < 4; k++) begin
                        if (MemBE[k]) tbMem[MemAddr[4:0]][8*k +: 8] = MemDataOut[8*k +: 8];
                    end
                end
            end else begin
                MemReady  = 1'b0;
                MemDataIn = $urandom;
            end
        end else begin
            csCount  = 0;
            MemReady = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (MemCS) begin
            if (!csPrev) begin
                if (busQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedMemCS actual=1 expected=0 t=%0t", $time);
                end else begin
                    curBus = busQ.pop_front();
                    checkOutput("memRW", 32'(MemRW), 32'(curBus.rw));
                    checkOutput("memAddr", 32'(MemAddr), 32'(curBus.addr));
                    checkOutput("memBE", 32'(MemBE), 32'(curBus.be));
                    if (curBus.checkData) checkOutput("memDataOut", MemDataOut, curBus.data);
                end
            end else begin
                checkOutput("memAddrHold", 32'(MemAddr), 32'(curBus.addr));
                checkOutput("memBEHold", 32'(MemBE), 32'(curBus.be));
                checkOutput("memRWHold", 32'(MemRW), 32'(curBus.rw));
                if (curBus.checkData) checkOutput("memDataHold", MemDataOut, curBus.data);
            end
        end
        csPrev = MemCS;
    end

    always @(negedge Clk) begin
        expResp_t e;
        if (Reset && Done) begin
            if (respQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedDone actual=1 expected=0 t=%0t", $time);
            end else begin
                e = respQ.pop_front();
                checkOutput("rdata", RData, e.rdata);
                checkOutput("busErr", 32'(BusErr), 32'(e.busErr));
                checkOutput("addrErr", 32'(AddrErr), 32'(e.addrErr));
                checkOutput("doneCycle", 32'(cycle), 32'(e.doneCycle));
            end
        end
    end

    // Called at a falling edge while idle; returns at a falling edge once the controller is idle again.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [6:0] addr, input logic [31:0] wdata, input int latency);
        expResp_t    r;
        busExp_t     b;
        int          c;
        int          nbytes;
        int          base;
        bit          misal;
        bit          finished;
        logic [31:0] v;
        respLatency = latency;
        Req    = 1'b1;
        Wr     = wr;
        Size   = size;
        Signed = sgn;
        Addr   = {25'b0, addr};
        WData  = wdata;
        @(posedge Clk);
        #1;
        c      = cycle;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base   = (int'(addr) / nbytes) * nbytes;
        misal  = 1'b0;
`ifdef LSU_ALIGN_CHK_EN
        misal  = (int'(addr) != base);
`endif
        if (misal) begin
            r = '{lastRData, 1'b0, 1'b1, c};
        end else begin
            b.rw        = wr;
            b.addr      = 30'(base / 4);
            b.be        = 4'b0000;
            b.data      = 32'h0;
            b.checkData = wr;
            for (int j = 0; j < nbytes; j++) b.be[(base + j) % 4] = 1'b1;
            for (int k = 0; k < 4; k++) b.data[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
            busQ.push_back(b);
            if (latency < 0) begin
                r = '{32'h0, 1'b1, 1'b0, c + 1 + TO};
                lastRData = 32'h0;
            end else if (wr) begin
                for (int j = 0; j < nbytes; j++) refMem[base + j] = wdata[8*j +: 8];
                r = '{lastRData, 1'b0, 1'b0, c + 2 + latency};
            end else begin
                v = 32'h0;
                for (int j = 0; j < nbytes; j++) v[8*j +: 8] = refMem[base + j];
                if (sgn && nbytes < 4 && v[8*nbytes-1]) begin
                    for (int j = nbytes; j < 4; j++) v[8*j +: 8] = 8'hFF;
                end
                r = '{v, 1'b0, 1'b0, c + 2 + latency};
                lastRData = v;
            end
        end
        respQ.push_back(r);
        finished = 1'b0;
        for (int i = 0; i < TO + 40 && !finished; i++) begin
            @(negedge Clk);
            if (!Busy) begin
                Req      = 1'b0;
                finished = 1'b1;
            end else begin
                Req    = 1'($urandom_range(0, 1));
                Wr     = 1'($urandom_range(0, 1));
                Size   = 2'($urandom_range(0, 3));
                Signed = 1'($urandom_range(0, 1));
                Addr   = $urandom;
                WData  = $urandom;
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL busyTimeout actual=busy expected=idle t=%0t", $time);
            Req = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        for (int i = 0; i < 128; i++) refMem[i] = 8'($urandom);
        for (int w = 0; w < 32; w++) tbMem[w] = {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};

        repeat (3) @(negedge Clk);
        checkOutput("rstBusy", 32'(Busy), 32'h0);
        checkOutput("rstDone", 32'(Done), 32'h0);
        checkOutput("rstMemCS", 32'(MemCS), 32'h0);
        checkOutput("rstMemRW", 32'(MemRW), 32'h0);
        checkOutput("rstMemBE", 32'(MemBE), 32'h0);
        checkOutput("rstMemAddr", 32'(MemAddr), 32'h0);
        checkOutput("rstMemDataOut", MemDataOut, 32'h0);
        checkOutput("rstRData", RData, 32'h0);
        checkOutput("rstBusErr", 32'(BusErr), 32'h0);
        checkOutput("rstAddrErr", 32'(AddrErr), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        applyStimulus(1'b1, 2'd2, 1'b0, 7'h40, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 2'd0, 1'b0, 7'h43, 32'h000000A5, 1);
        applyStimulus(1'b1, 2'd2, 1'b0, 7'h40, 32'h12F03456, 2);
        applyStimulus(1'b0, 2'd0, 1'b1, 7'h42, 32'h0, 0);
        checkOutput("specLoadByteSigned", RData, 32'hFFFFFFF0);
        applyStimulus(1'b0, 2'd0, 1'b0, 7'h42, 32'h0, 3);
        checkOutput("specLoadByteUnsigned", RData, 32'h000000F0);
        applyStimulus(1'b0, 2'd1, 1'b1, 7'h42, 32'h0, 0);
        checkOutput("specLoadHalfSigned", RData, 32'h000012F0);

        applyStimulus(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, -1);
        checkOutput("timeoutBusErr", 32'(BusErr), 32'h1);
        checkOutput("timeoutRData", RData, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 7'h40, 32'h0, 0);
        checkOutput("busErrCleared", 32'(BusErr), 32'h0);
        checkOutput("specLoadWord", RData, 32'h12F03456);

`ifdef LSU_ALIGN_CHK_EN
        applyStimulus(1'b0, 2'd2, 1'b0, 7'h42, 32'h0, 0);
        checkOutput("specMisalignedAddrErr", 32'(AddrErr), 32'h1);
`endif

        respLatency = -1;
        busQ.push_back('{1'b0, 30'h8, 4'hF, 32'h0, 1'b0});
        Req    = 1'b1;
        Wr     = 1'b0;
        Size   = 2'd2;
        Signed = 1'b0;
        Addr   = 32'h20;
        @(negedge Clk);
        Req = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("midResetMemCS", 32'(MemCS), 32'h0);
        checkOutput("midResetBusy", 32'(Busy), 32'h0);
        checkOutput("midResetDone", 32'(Done), 32'h0);
        checkOutput("midResetRData", RData, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        respQ.delete();
        lastRData = 32'h0;
        @(negedge Clk);
        applyStimulus(1'b0, 2'd2, 1'b0, 7'h40, 32'h0, 1);
        checkOutput("afterResetLoad", RData, 32'h12F03456);

        for (int n = 0; n < NUM_RANDOM; n++) begin
            lat = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          7'($urandom_range(0, 127)), $urandom, lat);
        end

        repeat (5) @(negedge Clk);
        checkOutput("respQueueDrained", 32'(respQ.size()), 32'h0);
        checkOutput("busQueueDrained", 32'(busQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
